// File: rtl/gray_counter_pkg.sv
// Shared channel indices and the binary-to-Gray helper for the Gray up/down counter.
package gray_counter_pkg;

  localparam int CH_UP   = 0;
  localparam int CH_DOWN = 1;
  localparam int CH_CLR  = 2;
  localparam int NUM_CH  = 3;

  // Widest count the helper handles; callers size-cast in and out of it.
  localparam int GRAY_MAX_W = 32;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/debounce_pulse.sv
// One button channel: 2-flop synchroniser, stable-time debouncer and a
// one-cycle pulse on the rising edge of the debounced level.
module debounce_pulse #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic noisy,
  output logic clean,
  output logic pulse
);

  localparam int            CW       = $clog2(DB_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          clean_q, clean_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive cycles where the synchronised input disagrees with the
  // clean level; flip the level once the disagreement has lasted long enough.
  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean_q;
    pulse_d = 1'b0;
    if (s2_q == clean_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      clean_d = ~clean_q;
      pulse_d = ~clean_q;   // only a 0->1 flip produces a press pulse
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Synchroniser, debounce state and registered pulse; reset drops any press in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      s1_q    <= noisy;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      pulse_q <= pulse_d;
    end
  end

  assign clean = clean_q;
  assign pulse = pulse_q;

endmodule

// File: rtl/gray_updown_counter_system.sv
// Three debounced buttons drive an N-bit up/down counter (N <= 32) shown on
// leds in Gray code; limit_evt flags every wrap or blocked step.
module gray_updown_counter_system
  import gray_counter_pkg::*;
#(
  parameter int N         = 8,
  parameter int DB_CYCLES = 16,
  parameter bit WRAP      = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         noisy_up,
  input  logic         noisy_down,
  input  logic         noisy_clr,
  output logic [N-1:0] leds,
  output logic         limit_evt
);

  localparam logic [N-1:0] BIN_MAX = '1;

  logic [NUM_CH-1:0] noisy_w;
  logic [NUM_CH-1:0] pulse_w;
  logic [NUM_CH-1:0] clean_unused;

  logic [N-1:0] bin_q, bin_d;
  logic [N-1:0] leds_q;
  logic         evt_q, evt_d;

  assign noisy_w[CH_UP]   = noisy_up;
  assign noisy_w[CH_DOWN] = noisy_down;
  assign noisy_w[CH_CLR]  = noisy_clr;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    debounce_pulse #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk   (clk),
      .reset (reset),
      .noisy (noisy_w[ch]),
      .clean (clean_unused[ch]),
      .pulse (pulse_w[ch])
    );
  end

  // Next count from this cycle's pulses: clear wins, up+down cancel, limits wrap or saturate.
  always_comb begin
    bin_d = bin_q;
    evt_d = 1'b0;
    if (pulse_w[CH_CLR]) begin
      bin_d = '0;
    end else if (pulse_w[CH_UP] && pulse_w[CH_DOWN]) begin
      bin_d = bin_q;
    end else if (pulse_w[CH_UP]) begin
      if (bin_q == BIN_MAX) begin
        evt_d = 1'b1;
        if (WRAP) bin_d = '0;
      end else begin
        bin_d = bin_q + 1'b1;
      end
    end else if (pulse_w[CH_DOWN]) begin
      if (bin_q == '0) begin
        evt_d = 1'b1;
        if (WRAP) bin_d = BIN_MAX;
      end else begin
        bin_d = bin_q - 1'b1;
      end
    end
  end

  // Count, Gray output and event flag all update on the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bin_q  <= '0;
      leds_q <= '0;
      evt_q  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      leds_q <= N'(bin2gray(GRAY_MAX_W'(bin_d)));
      evt_q  <= evt_d;
    end
  end

  assign leds      = leds_q;
  assign limit_evt = evt_q;

endmodule
